// File: rtl/video_dram_pkg.sv
`default_nettype none
// =============================================================================
// Module : video_dram_pkg
// Brief  : Slot types, phase constants and field layout for plane-B DRAM timing.
// Rev    : 1.0
// =============================================================================
package video_dram_pkg;

    localparam int SLOT_CYC = 8;
    localparam int PH_W     = $clog2(SLOT_CYC);
    localparam int ADDR_W   = 14;
    localparam int ROW_W    = 7;
    localparam int DATA_W   = 16;

    typedef logic [PH_W-1:0] phase_t;

    typedef enum logic [1:0] {
        SLOT_IDLE = 2'd0,
        SLOT_VID  = 2'd1,
        SLOT_WR   = 2'd2,
        SLOT_REF  = 2'd3
    } slot_t;

    localparam phase_t PH_RAS_ON = phase_t'(1);
    localparam phase_t PH_COL    = phase_t'(2);
    localparam phase_t PH_CAS_ON = phase_t'(3);
    localparam phase_t PH_WE_OFF = phase_t'(6);
    localparam phase_t PH_LD     = phase_t'(6);
    localparam phase_t PH_DECIDE = phase_t'(7);

    // DX / WR_DATA nibble layout {R,G,B,Z}
    localparam int DX_NIB_W = 4;
    localparam int DX_R_LSB = 12;
    localparam int DX_G_LSB = 8;
    localparam int DX_B_LSB = 4;
    localparam int DX_Z_LSB = 0;

endpackage
`default_nettype wire

// File: rtl/video_refresh_timer.sv
`default_nettype none
// =============================================================================
// Module : video_refresh_timer
// Brief  : Refresh period counter with saturating pending count and sticky overflow.
// Rev    : 1.0
// =============================================================================
module video_refresh_timer #(
    parameter int REF_PERIOD   = 124,
    parameter int REF_PEND_MAX = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_dec,
    output logic o_pend_nz,
    output logic o_ref_ovf
);

    localparam int TW = $clog2(REF_PERIOD);
    localparam int PW = $clog2(REF_PEND_MAX + 1);
    localparam logic [TW-1:0] C_TMR_LAST = TW'(REF_PERIOD - 1);
    localparam logic [PW-1:0] C_PEND_MAX = PW'(REF_PEND_MAX);

    logic [TW-1:0] r_tmr;
    logic [PW-1:0] r_pend;
    logic          r_ovf;
    logic          w_tick;

    assign w_tick    = (r_tmr == C_TMR_LAST);
    assign o_pend_nz = |r_pend;
    assign o_ref_ovf = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmr  <= '0;
            r_pend <= '0;
            r_ovf  <= 1'b0;
        end else begin
            r_tmr <= w_tick ? '0 : r_tmr + TW'(1);
            // A tick coinciding with a decrement leaves the count unchanged.
            case ({w_tick, i_dec})
                2'b10: begin
                    if (r_pend == C_PEND_MAX) r_ovf  <= 1'b1;
                    else                      r_pend <= r_pend + PW'(1);
                end
                2'b01: begin
                    if (r_pend != '0) r_pend <= r_pend - PW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/video_motion_dram_ctrl.sv
`default_nettype none
// =============================================================================
// Module : video_motion_dram_ctrl
// Brief  : Slot arbiter and strobe generator for motion-object DRAM plane B.
// Rev    : 1.0
// =============================================================================
module video_motion_dram_ctrl
    import video_dram_pkg::*;
#(
    parameter int REF_PERIOD   = 124,
    parameter int REF_PEND_MAX = 7
) (
    input  logic        CLK,
    input  logic        RST_AL,
    input  logic        VID_ACTIVE,
    input  logic [13:0] VID_ADDR,
    input  logic        WR_REQ,
    input  logic        WR_BANK,
    input  logic [13:0] WR_ADDR,
    input  logic [15:0] WR_DATA,
    output logic        WR_ACK,
    output logic [6:0]  XXB,
    output logic        BRAS0_AL,
    output logic        BRAS1_AL,
    output logic        BCAS0_AL,
    output logic        BCAS1_AL,
    output logic        BWE0_AL,
    output logic        BWE1_AL,
    output logic [15:0] DX,
    output logic        SFT_AL,
    output logic        LD_SFT_AL,
    output logic        REF_OVF
);

    slot_t              r_slot;
    phase_t             r_phase;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_bank;
    logic [ROW_W-1:0]   r_rrow;
    logic [DATA_W-1:0]  r_dx;
    logic [ROW_W-1:0]   r_xxb;
    logic [1:0]         r_bras;
    logic [1:0]         r_bcas;
    logic [1:0]         r_bwe;
    logic               r_sft;
    logic               r_ld;
    logic               r_ack;

    slot_t              w_slot_nxt;
    phase_t             w_phase_nxt;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic               w_bank_nxt;
    logic [ROW_W-1:0]   w_rrow_nxt;
    logic [DATA_W-1:0]  w_dx_nxt;
    logic               w_ref_dec;
    logic               w_ref_pend;
    logic               w_ref_ovf;
    logic               w_ras_on;
    logic               w_cas_on;
    logic               w_we_on;
    logic [ROW_W-1:0]   w_xxb_nxt;
    logic [1:0]         w_bras_nxt;
    logic [1:0]         w_bcas_nxt;
    logic [1:0]         w_bwe_nxt;
    logic               w_sft_nxt;
    logic               w_ld_nxt;
    logic               w_ack_nxt;

    video_refresh_timer #(
        .REF_PERIOD   (REF_PERIOD),
        .REF_PEND_MAX (REF_PEND_MAX)
    ) u_ref_timer (
        .clk       (CLK),
        .rst_n     (RST_AL),
        .i_dec     (w_ref_dec),
        .o_pend_nz (w_ref_pend),
        .o_ref_ovf (w_ref_ovf)
    );

    always_ff @(posedge CLK or negedge RST_AL) begin
        if (!RST_AL) begin
            r_slot  <= SLOT_IDLE;
            r_phase <= '0;
        end else begin
            r_slot  <= w_slot_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    // Next-slot decision and per-slot latches
    always_comb begin
        w_phase_nxt = r_phase + phase_t'(1);
        w_slot_nxt  = r_slot;
        w_addr_nxt  = r_addr;
        w_bank_nxt  = r_bank;
        w_dx_nxt    = r_dx;
        w_rrow_nxt  = r_rrow;
        w_ref_dec   = 1'b0;
        if (r_phase == PH_DECIDE) begin
            if (r_slot == SLOT_REF) w_rrow_nxt = r_rrow + ROW_W'(1);
            if (VID_ACTIVE) begin
                w_slot_nxt = SLOT_VID;
                w_addr_nxt = VID_ADDR;
            end else if (w_ref_pend) begin
                w_slot_nxt = SLOT_REF;
                w_ref_dec  = 1'b1;
            end else if (WR_REQ) begin
                w_slot_nxt = SLOT_WR;
                w_addr_nxt = WR_ADDR;
                w_bank_nxt = WR_BANK;
                w_dx_nxt   = WR_DATA;
            end else begin
                w_slot_nxt = SLOT_IDLE;
            end
        end
    end

    // Outputs are computed for the upcoming phase and registered, so every
    // strobe changes only on a clock edge and lines up with r_phase.
    always_comb begin
        w_ras_on   = (w_phase_nxt >= PH_RAS_ON) && (w_phase_nxt < PH_DECIDE);
        w_cas_on   = (w_phase_nxt >= PH_CAS_ON) && (w_phase_nxt < PH_DECIDE);
        w_we_on    = (w_phase_nxt >= PH_CAS_ON) && (w_phase_nxt < PH_WE_OFF);
        w_xxb_nxt  = (w_phase_nxt < PH_COL) ? w_addr_nxt[ROW_W-1:0]
                                            : w_addr_nxt[ADDR_W-1:ROW_W];
        w_bras_nxt = 2'b11;
        w_bcas_nxt = 2'b11;
        w_bwe_nxt  = 2'b11;
        w_ld_nxt   = 1'b1;
        w_ack_nxt  = 1'b0;
        w_sft_nxt  = ~w_phase_nxt[0];
        case (w_slot_nxt)
            SLOT_VID: begin
                w_bras_nxt = {2{~w_ras_on}};
                w_bcas_nxt = {2{~w_cas_on}};
                w_ld_nxt   = ~(w_phase_nxt >= PH_LD);
            end
            SLOT_WR: begin
                w_ack_nxt = (w_phase_nxt == '0);
                if (w_bank_nxt) begin
                    w_bras_nxt[1] = ~w_ras_on;
                    w_bcas_nxt[1] = ~w_cas_on;
                    w_bwe_nxt[1]  = ~w_we_on;
                end else begin
                    w_bras_nxt[0] = ~w_ras_on;
                    w_bcas_nxt[0] = ~w_cas_on;
                    w_bwe_nxt[0]  = ~w_we_on;
                end
            end
            SLOT_REF: begin
                w_bras_nxt = {2{~w_ras_on}};
                w_xxb_nxt  = w_rrow_nxt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_AL) begin
        if (!RST_AL) begin
            r_addr <= '0;
            r_bank <= 1'b0;
            r_rrow <= '0;
            r_dx   <= '0;
            r_xxb  <= '0;
            r_bras <= 2'b11;
            r_bcas <= 2'b11;
            r_bwe  <= 2'b11;
            r_sft  <= 1'b1;
            r_ld   <= 1'b1;
            r_ack  <= 1'b0;
        end else begin
            r_addr <= w_addr_nxt;
            r_bank <= w_bank_nxt;
            r_rrow <= w_rrow_nxt;
            r_dx   <= w_dx_nxt;
            r_xxb  <= w_xxb_nxt;
            r_bras <= w_bras_nxt;
            r_bcas <= w_bcas_nxt;
            r_bwe  <= w_bwe_nxt;
            r_sft  <= w_sft_nxt;
            r_ld   <= w_ld_nxt;
            r_ack  <= w_ack_nxt;
        end
    end

    assign XXB       = r_xxb;
    assign DX        = r_dx;
    assign BRAS0_AL  = r_bras[0];
    assign BRAS1_AL  = r_bras[1];
    assign BCAS0_AL  = r_bcas[0];
    assign BCAS1_AL  = r_bcas[1];
    assign BWE0_AL   = r_bwe[0];
    assign BWE1_AL   = r_bwe[1];
    assign SFT_AL    = r_sft;
    assign LD_SFT_AL = r_ld;
    assign WR_ACK    = r_ack;
    assign REF_OVF   = w_ref_ovf;

endmodule
`default_nettype wire
